// File: rtl/window_analysis_pkg.sv
// Shared definitions for the multichannel window analyser: peak-mode codes,
// record field placement helpers and the controller state encoding.
package window_analysis_pkg;

  localparam logic [1:0] MODE_MAX = 2'd0;
  localparam logic [1:0] MODE_MIN = 2'd1;
  localparam logic [1:0] MODE_ABS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ACCUM = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  // Record layout, MSB to LSB: cycle, channel, overrun, mean, peak, peak index.
  function automatic int rec_width(int cns, int chw, int s, int mp);
    return cns + chw + 1 + 2 * s + mp;
  endfunction

  function automatic int off_pidx();
    return 0;
  endfunction

  function automatic int off_peak(int mp);
    return mp;
  endfunction

  function automatic int off_mean(int s, int mp);
    return mp + s;
  endfunction

  function automatic int off_ovr(int s, int mp);
    return mp + 2 * s;
  endfunction

  function automatic int off_ch(int s, int mp);
    return mp + 2 * s + 1;
  endfunction

  function automatic int off_cyc(int chw, int s, int mp);
    return mp + 2 * s + 1 + chw;
  endfunction

endpackage

// File: rtl/window_fifo.sv
// Synchronous record FIFO with count-derived registered state flags and a
// saturating counter of writes refused because the FIFO was full.
module window_fifo
  import window_analysis_pkg::*;
#(
  parameter int WIDTH  = 19,
  parameter int DEPTH  = 8,
  parameter int ALMOST = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [3:0]       state_o,
  output logic [7:0]       drop_count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [3:0]       state_q;
  logic [7:0]       drop_q;
  logic             wr_ok, rd_ok;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO refuses writes even when a pop frees a slot on the same edge.
  assign wr_ok = wr_en_i && (cnt_q != CNT_W'(DEPTH));
  assign rd_ok = rd_en_i && (cnt_q != '0);

  // Occupancy after this edge; a simultaneous accepted read and write cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_ok && !rd_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Record storage; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  // Pointers, occupancy, read port, state flags and the drop counter.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      state_q    <= 4'b0101;
      drop_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_ok;
      if (wr_ok) begin
        wptr_q <= next_ptr(wptr_q);
      end
      if (rd_ok) begin
        rptr_q    <= next_ptr(rptr_q);
        rd_data_q <= mem_q[rptr_q];
      end
      state_q <= {cnt_d == CNT_W'(DEPTH),
                  cnt_d == '0,
                  cnt_d >= CNT_W'(DEPTH - ALMOST),
                  cnt_d <= CNT_W'(ALMOST)};
      if (wr_en_i && !wr_ok && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign state_o      = state_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/window_analysis_mc.sv
// Multichannel window analyser: after a start strobe and a programmable delay,
// accumulates 2^P samples per channel, computes floor mean and a mode-selected
// peak with its index, and queues one tagged record per channel in a FIFO.
module window_analysis_mc
  import window_analysis_pkg::*;
#(
  parameter int CHANNELS          = 2,
  parameter int SAMPLE_DATA_SIZE  = 4,
  parameter int WINDOW_DELAY_SIZE = 4,
  parameter int MAX_WINDOW_POW    = 4,
  parameter int POW_SIZE          = 3,
  parameter int CYCLE_NUMBER_SIZE = 5,
  parameter int FIFO_DEPTH        = 8,
  parameter int ALMOST_LEVEL      = 2,
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int REC_W = rec_width(CYCLE_NUMBER_SIZE, CH_W, SAMPLE_DATA_SIZE, MAX_WINDOW_POW)
) (
  input  logic                                 clk,
  input  logic                                 rst_in,
  input  logic                                 cycle_start_in,
  input  logic [WINDOW_DELAY_SIZE-1:0]         window_delay_in,
  input  logic [POW_SIZE-1:0]                  window_pow_in,
  input  logic [1:0]                           mode_in,
  input  logic [CHANNELS*SAMPLE_DATA_SIZE-1:0] sample_data_in,
  input  logic                                 read_enable_in,
  output logic [REC_W-1:0]                     read_data_out,
  output logic                                 read_valid_out,
  output logic [3:0]                           fifo_state_out,
  output logic [7:0]                           drop_count_out
);

  localparam int S        = SAMPLE_DATA_SIZE;
  localparam int MP       = MAX_WINDOW_POW;
  localparam int SUM_W    = S + MP;
  localparam int OFF_PIDX = off_pidx();
  localparam int OFF_PEAK = off_peak(MP);
  localparam int OFF_MEAN = off_mean(S, MP);
  localparam int OFF_OVR  = off_ovr(S, MP);
  localparam int OFF_CH   = off_ch(S, MP);
  localparam int OFF_CYC  = off_cyc(CH_W, S, MP);

  state_e                         state_q;
  logic [WINDOW_DELAY_SIZE-1:0]   dly_q;
  logic [POW_SIZE-1:0]            pow_q;
  logic [POW_SIZE-1:0]            pow_clamped;
  logic [1:0]                     mode_q;
  logic [MP-1:0]                  idx_q;
  logic [MP-1:0]                  last_idx;
  logic [CH_W-1:0]                fch_q;
  logic [CYCLE_NUMBER_SIZE-1:0]   cyc_q;
  logic                           ovr_q;
  logic                           cyc_ovr_q;
  logic                           clr, cap, wr_en;
  logic [CHANNELS-1:0][REC_W-1:0] rec_a;
  logic [REC_W-1:0]               wr_data;

  // Offset-binary to two's complement: flip the MSB.
  function automatic logic signed [S-1:0] to_signed(logic [S-1:0] raw);
    return {~raw[S-1], raw[S-2:0]};
  endfunction

  // Magnitude one bit wider so the most-negative sample is the largest.
  function automatic logic [S:0] mag(logic signed [S-1:0] x);
    logic signed [S:0] e;
    e = (S+1)'(x);
    return (e < 0) ? $unsigned(-e) : $unsigned(e);
  endfunction

  // Arithmetic shift floors toward minus infinity; the result always fits S bits.
  function automatic logic signed [S-1:0] floor_mean(logic signed [SUM_W-1:0] sum,
                                                     logic [POW_SIZE-1:0] p);
    return S'(sum >>> p);
  endfunction

  assign pow_clamped = (window_pow_in > POW_SIZE'(MP)) ? POW_SIZE'(MP) : window_pow_in;
  assign last_idx    = MP'((1 << pow_q) - 1);
  assign clr         = (state_q == S_IDLE) && cycle_start_in;
  assign cap         = (state_q == S_ACCUM);
  assign wr_en       = (state_q == S_FLUSH);
  assign wr_data     = rec_a[fch_q];

  // Cycle controller: start latch, delay count, window count, per-channel flush.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      pow_q     <= '0;
      mode_q    <= MODE_MAX;
      idx_q     <= '0;
      fch_q     <= '0;
      cyc_q     <= '0;
      ovr_q     <= 1'b0;
      cyc_ovr_q <= 1'b0;
    end else begin
      if (cycle_start_in && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (cycle_start_in) begin
            dly_q     <= window_delay_in;
            pow_q     <= pow_clamped;
            mode_q    <= mode_in;
            idx_q     <= '0;
            cyc_ovr_q <= ovr_q;
            ovr_q     <= 1'b0;
            state_q   <= (window_delay_in == '0) ? S_ACCUM : S_DELAY;
          end
        end
        S_DELAY: begin
          if (dly_q == WINDOW_DELAY_SIZE'(1)) begin
            state_q <= S_ACCUM;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        S_ACCUM: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == last_idx) begin
            fch_q   <= '0;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          fch_q <= fch_q + 1'b1;
          if (fch_q == CH_W'(CHANNELS - 1)) begin
            cyc_q   <= cyc_q + 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic signed [S-1:0]     smp;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic signed [S-1:0]     peak_q, peak_d;
    logic [MP-1:0]           pidx_q, pidx_d;
    logic                    better;
    logic [REC_W-1:0]        rec;

    assign smp = to_signed(sample_data_in[k*S +: S]);

    // Strict comparison under the latched mode, so ties keep the earlier sample.
    always_comb begin
      better = 1'b0;
      case (mode_q)
        MODE_MIN: better = (smp < peak_q);
        MODE_ABS: better = (mag(smp) > mag(peak_q));
        default:  better = (smp > peak_q);
      endcase
    end

    // Accumulator next state: cleared on an accepted start, updated while capturing.
    always_comb begin
      sum_d  = sum_q;
      peak_d = peak_q;
      pidx_d = pidx_q;
      if (clr) begin
        sum_d  = '0;
        peak_d = '0;
        pidx_d = '0;
      end else if (cap) begin
        sum_d = sum_q + SUM_W'(smp);
        if ((idx_q == '0) || better) begin
          peak_d = smp;
          pidx_d = idx_q;
        end
      end
    end

    // Accumulator registers carry data only and are rebuilt by every start.
    always_ff @(posedge clk) begin
      sum_q  <= sum_d;
      peak_q <= peak_d;
      pidx_q <= pidx_d;
    end

    // Assemble this channel's record from the finished accumulators.
    always_comb begin
      rec = '0;
      rec[OFF_CYC  +: CYCLE_NUMBER_SIZE] = cyc_q;
      rec[OFF_CH   +: CH_W]              = CH_W'(k);
      rec[OFF_OVR]                       = cyc_ovr_q;
      rec[OFF_MEAN +: S]                 = floor_mean(sum_q, pow_q);
      rec[OFF_PEAK +: S]                 = peak_q;
      rec[OFF_PIDX +: MP]                = pidx_q;
    end

    assign rec_a[k] = rec;
  end

  window_fifo #(
    .WIDTH  (REC_W),
    .DEPTH  (FIFO_DEPTH),
    .ALMOST (ALMOST_LEVEL)
  ) u_fifo (
    .clk          (clk),
    .rst_i        (rst_in),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .rd_en_i      (read_enable_in),
    .rd_data_o    (read_data_out),
    .rd_valid_o   (read_valid_out),
    .state_o      (fifo_state_out),
    .drop_count_o (drop_count_out)
  );

endmodule

// File: tb/tb_window_analysis_mc.sv
// Bench for window_analysis_mc: directed and randomized analysis cycles checked
// against a record-level reference model and a queue-based FIFO model.
module tb_window_analysis_mc;

  localparam int CH    = 2;
  localparam int MP    = 4;
  localparam int REC_W = 19;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_in;
  logic             cycle_start_in;
  logic [3:0]       window_delay_in;
  logic [2:0]       window_pow_in;
  logic [1:0]       mode_in;
  logic [7:0]       sample_data_in;
  logic             read_enable_in;
  logic [REC_W-1:0] read_data_out;
  logic             read_valid_out;
  logic [3:0]       fifo_state_out;
  logic [7:0]       drop_count_out;

  int checks = 0;
  int errors = 0;

  int               win [CH][16];
  logic [REC_W-1:0] mq[$];
  int               mcyc;
  int               mdrop;
  bit               movr;
  logic [REC_W-1:0] last_pop;

  window_analysis_mc dut (
    .clk             (clk),
    .rst_in          (rst_in),
    .cycle_start_in  (cycle_start_in),
    .window_delay_in (window_delay_in),
    .window_pow_in   (window_pow_in),
    .mode_in         (mode_in),
    .sample_data_in  (sample_data_in),
    .read_enable_in  (read_enable_in),
    .read_data_out   (read_data_out),
    .read_valid_out  (read_valid_out),
    .fifo_state_out  (fifo_state_out),
    .drop_count_out  (drop_count_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] enc(int x);
    return 4'(x + 8);
  endfunction

  task automatic drive(int a, int b);
    sample_data_in = {enc(b), enc(a)};
  endtask

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [3:0] exp_state();
    int c;
    c = mq.size();
    return {c == DEPTH, c == 0, c >= DEPTH - 2, c <= 2};
  endfunction

  // Reference record from the window contents using plain integer arithmetic.
  function automatic logic [REC_W-1:0] model_rec(int ch, int n, int mode, int cyc, bit ovr);
    int  sum, mean, pk, pi;
    bit  better;
    sum = 0;
    for (int i = 0; i < n; i++) sum += win[ch][i];
    mean = (sum >= 0) ? sum / n : -((-sum + n - 1) / n);
    pk = win[ch][0];
    pi = 0;
    for (int i = 1; i < n; i++) begin
      case (mode)
        1:       better = win[ch][i] < pk;
        2:       better = iabs(win[ch][i]) > iabs(pk);
        default: better = win[ch][i] > pk;
      endcase
      if (better) begin
        pk = win[ch][i];
        pi = i;
      end
    end
    return {5'(cyc), 1'(ch), ovr, 4'(mean), 4'(pk), 4'(pi)};
  endfunction

  task automatic model_write(logic [REC_W-1:0] r);
    if (mq.size() < DEPTH) mq.push_back(r);
    else if (mdrop < 255) mdrop++;
  endtask

  task automatic model_reset();
    mq.delete();
    mcyc  = 0;
    mdrop = 0;
    movr  = 1'b0;
  endtask

  task automatic fill_rand(int n);
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < n; i++)
        win[c][i] = int'($urandom_range(0, 15)) - 8;
  endtask

  task automatic set4(int ch, int a, int b, int c, int d);
    win[ch][0] = a; win[ch][1] = b; win[ch][2] = c; win[ch][3] = d;
  endtask

  // One analysis cycle; extreme samples outside the window expose mis-timed capture.
  task automatic run_cycle(int d, int p, int mode, bit extra);
    int n;
    n = 1 << ((p > MP) ? MP : p);
    cycle_start_in  = 1'b1;
    window_delay_in = 4'(d);
    window_pow_in   = 3'(p);
    mode_in         = 2'(mode);
    drive(7, -8);
    @(negedge clk);
    cycle_start_in = 1'b0;
    for (int e = 1; e <= d; e++) begin
      drive(7, -8);
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      drive(win[0][i], win[1][i]);
      cycle_start_in = extra && (i == 1);
      @(negedge clk);
    end
    cycle_start_in = 1'b0;
    for (int c = 0; c < CH; c++) begin
      drive(7, -8);
      @(negedge clk);
    end
    for (int c = 0; c < CH; c++) model_write(model_rec(c, n, mode, mcyc, movr));
    movr = extra;
    mcyc = (mcyc + 1) % 32;
    chk("cycle_state", fifo_state_out, exp_state());
    chk("cycle_drop", drop_count_out, mdrop);
  endtask

  task automatic pop(string tag, output logic [REC_W-1:0] r);
    logic [REC_W-1:0] e;
    read_enable_in = 1'b1;
    @(negedge clk);
    read_enable_in = 1'b0;
    e = mq.pop_front();
    last_pop = e;
    r = read_data_out;
    chk({tag, "_vld"}, read_valid_out, 1);
    chk({tag, "_rec"}, read_data_out, e);
    chk({tag, "_state"}, fifo_state_out, exp_state());
  endtask

  task automatic drain(string tag);
    logic [REC_W-1:0] r;
    while (mq.size() > 0) pop(tag, r);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [REC_W-1:0] r;
    rst_in          = 1'b1;
    cycle_start_in  = 1'b0;
    window_delay_in = '0;
    window_pow_in   = '0;
    mode_in         = '0;
    read_enable_in  = 1'b0;
    drive(0, 0);
    last_pop        = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", read_data_out, 0);
    chk("rst_vld", read_valid_out, 0);
    chk("rst_state", fifo_state_out, 4'b0101);
    chk("rst_drop", drop_count_out, 0);
    rst_in = 1'b0;
    @(negedge clk);

    // Max mode, delayed window; the sample at edge D must be ignored.
    fill_rand(4);
    set4(0, 1, 3, -2, 3);
    run_cycle(3, 2, 0, 1'b0);
    pop("A0", r);
    chk("A0_fields", r, {5'd0, 1'b0, 1'b0, 4'd1, 4'd3, 4'd1});
    pop("A1", r);

    // Min mode with a floor-rounded negative mean.
    fill_rand(4);
    set4(1, -1, -4, -8, 2);
    run_cycle(0, 2, 1, 1'b0);
    pop("B0", r);
    pop("B1", r);
    chk("B1_fields", r[13:0], {1'b1, 1'b0, 4'hD, 4'h8, 4'd2});

    // Max-abs mode; the later tie at index 3 must not replace index 1.
    fill_rand(4);
    set4(1, 1, -8, 7, -8);
    run_cycle(1, 2, 2, 1'b0);
    pop("C0", r);
    pop("C1", r);
    chk("C1_fields", r[13:0], {1'b1, 1'b0, 4'hE, 4'h8, 4'd1});

    // Start pulse during capture flags the following cycle only.
    fill_rand(8);
    run_cycle(2, 3, 0, 1'b1);
    fill_rand(4);
    run_cycle(1, 2, 3, 1'b0);
    fill_rand(2);
    run_cycle(0, 1, 2, 1'b0);
    pop("O0", r);
    chk("O0_ovr", r[12], 0);
    pop("O1", r);
    pop("O2", r);
    chk("O2_ovr", r[12], 1);
    pop("O3", r);
    chk("O3_ovr", r[12], 1);
    pop("O4", r);
    chk("O4_ovr", r[12], 0);
    pop("O5", r);

    // Randomized cycles, including pow values above the legal maximum.
    for (int t = 0; t < 5; t++) begin
      fill_rand(16);
      run_cycle($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
      drain("R");
    end

    // Overfill: five cycles, no reads.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      fill_rand(2);
      run_cycle($urandom_range(0, 3), 1, $urandom_range(0, 3), 1'b0);
    end
    chk("full_state", fifo_state_out, 4'b1010);
    chk("full_drop", drop_count_out, 2);
    for (int i = 0; i < DEPTH; i++) begin
      pop("F", r);
      chk("F_cyc", r[18:14], i / 2);
    end

    // Pop on an empty FIFO is ignored and the read port holds.
    read_enable_in = 1'b1;
    @(negedge clk);
    read_enable_in = 1'b0;
    chk("E_vld", read_valid_out, 0);
    chk("E_hold", read_data_out, last_pop);
    chk("E_state", fifo_state_out, 4'b0101);

    // Reset while flushing discards the cycle and restarts numbering.
    cycle_start_in  = 1'b1;
    window_delay_in = 4'd0;
    window_pow_in   = 3'd0;
    mode_in         = 2'd0;
    drive(3, -3);
    @(negedge clk);
    cycle_start_in = 1'b0;
    drive(5, -5);
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    model_reset();
    chk("X_state", fifo_state_out, 4'b0101);
    chk("X_drop", drop_count_out, 0);
    chk("X_vld", read_valid_out, 0);
    chk("X_data", read_data_out, 0);
    fill_rand(2);
    run_cycle(1, 1, 0, 1'b0);
    pop("X0", r);
    chk("X0_cyc", r[18:14], 0);
    pop("X1", r);
    chk("X1_cyc", r[18:14], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
